// File: rtl/wishbone_arbiter_pkg.sv
// Shared types for the two-master / three-slave Wishbone arbiter: FSM encoding,
// slave indices and slave count.
package wishbone_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam int NUM_SLAVES = 3;
  localparam int SLV_FLASH  = 0;
  localparam int SLV_MEM    = 1;
  localparam int SLV_CTRL   = 2;

endpackage

// File: rtl/wishbone_address_decoder.sv
// Combinational address decode: one-hot hit per slave window [BASE, BASE+SIZE).
// The compare is done at 33 bits so a window ending at 4 GiB cannot wrap.
module wishbone_address_decoder
  import wishbone_arbiter_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h1000_0000,
  parameter logic [31:0] S0_SIZE = 32'h0020_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_SIZE = 32'h0000_4000,
  parameter logic [31:0] S2_BASE = 32'h3000_0000,
  parameter logic [31:0] S2_SIZE = 32'h0000_0100
) (
  input  logic [31:0]           adr,
  output logic [NUM_SLAVES-1:0] hit
);

  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  always_comb begin
    hit            = '0;
    hit[SLV_FLASH] = in_window(adr, S0_BASE, S0_SIZE);
    hit[SLV_MEM]   = in_window(adr, S1_BASE, S1_SIZE);
    hit[SLV_CTRL]  = in_window(adr, S2_BASE, S2_SIZE);
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic bus between two masters, with
// address decode to three slaves and err on unmapped accesses.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// Handshake: a granted master owns the bus from grant until it drops cyc; a
// beat completes on any edge where stb is high and one of ack/err/rty is high.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter logic [31:0] S0_BASE        = 32'h1000_0000,
  parameter logic [31:0] S0_SIZE        = 32'h0020_0000,
  parameter logic [31:0] S1_BASE        = 32'h2000_0000,
  parameter logic [31:0] S1_SIZE        = 32'h0000_4000,
  parameter logic [31:0] S2_BASE        = 32'h3000_0000,
  parameter logic [31:0] S2_SIZE        = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [31:0]           m0_adr_i,
  input  logic [31:0]           m0_dat_i,
  input  logic [3:0]            m0_sel_i,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [31:0]           m1_adr_i,
  input  logic [31:0]           m1_dat_i,
  input  logic [3:0]            m1_sel_i,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic [NUM_SLAVES-1:0] s_cyc_o,
  output logic [NUM_SLAVES-1:0] s_stb_o,
  input  logic [31:0]           s0_dat_i,
  input  logic                  s0_ack_i,
  input  logic                  s0_err_i,
  input  logic                  s0_rty_i,
  input  logic [31:0]           s1_dat_i,
  input  logic                  s1_ack_i,
  input  logic                  s1_err_i,
  input  logic                  s1_rty_i,
  input  logic [31:0]           s2_dat_i,
  input  logic                  s2_ack_i,
  input  logic                  s2_err_i,
  input  logic                  s2_rty_i,
  output arb_state_t            dbg_state_o
);

  arb_state_t state_q, state_d;
  logic       rr_last_q, rr_last_d;   // index of the master granted most recently
  logic       dec_err_q;
  logic       to_err_q;

  logic                  g_cyc, g_stb, g_we;
  logic [31:0]           g_adr, g_dat;
  logic [3:0]            g_sel;
  logic [NUM_SLAVES-1:0] hit, sel_hit;
  logic [31:0]           r_dat;
  logic                  r_ack, r_err, r_rty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (rr_last_q) begin
            state_d   = ST_GNT0;
            rr_last_d = 1'b0;
          end else begin
            state_d   = ST_GNT1;
            rr_last_d = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d   = ST_GNT0;
          rr_last_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d   = ST_GNT1;
          rr_last_d = 1'b1;
        end
      end
      ST_GNT0: if (!m0_cyc_i) state_d = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Granted-master request; all zero while idle so the slave bus is quiet.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    case (state_q)
      ST_GNT0: begin
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
        g_we  = m0_we_i;
        g_adr = m0_adr_i;
        g_dat = m0_dat_i;
        g_sel = m0_sel_i;
      end
      ST_GNT1: begin
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
        g_we  = m1_we_i;
        g_adr = m1_adr_i;
        g_dat = m1_dat_i;
        g_sel = m1_sel_i;
      end
      default: ;
    endcase
  end

  wishbone_address_decoder #(
    .S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE),
    .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE),
    .S2_BASE(S2_BASE), .S2_SIZE(S2_SIZE)
  ) u_decoder (
    .adr(g_adr),
    .hit(hit)
  );

  assign sel_hit = g_cyc ? hit : '0;
  assign s_cyc_o = sel_hit;
  assign s_stb_o = sel_hit & {NUM_SLAVES{g_stb}};
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;

  // Multiple response bits from one slave are passed through untouched.
  always_comb begin
    r_dat = '0;
    r_ack = 1'b0;
    r_err = 1'b0;
    r_rty = 1'b0;
    if (sel_hit[SLV_FLASH]) begin
      r_dat = s0_dat_i;
      r_ack = s0_ack_i;
      r_err = s0_err_i;
      r_rty = s0_rty_i;
    end else if (sel_hit[SLV_MEM]) begin
      r_dat = s1_dat_i;
      r_ack = s1_ack_i;
      r_err = s1_err_i;
      r_rty = s1_rty_i;
    end else if (sel_hit[SLV_CTRL]) begin
      r_dat = s2_dat_i;
      r_ack = s2_ack_i;
      r_err = s2_err_i;
      r_rty = s2_rty_i;
    end
  end

  // Self-clearing: a held miss strobe yields err on alternate cycles only.
  always_ff @(posedge clk_i) begin
    if (rst_i) dec_err_q <= 1'b0;
    else       dec_err_q <= g_cyc && g_stb && (hit == '0) && !dec_err_q;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Flag is registered one count early so err lands on the TIMEOUT_CYCLES-th strobe cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      if (g_cyc && g_stb && (hit != '0) && !(r_ack || r_err || r_rty || to_err_q)) begin
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 2)) begin
          to_cnt_q <= '0;
          to_err_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end
`else
  // No watchdog: the parameter is only referenced to keep the interface uniform.
  assign to_err_q = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign m0_dat_o = (state_q == ST_GNT0) ? r_dat : '0;
  assign m0_ack_o = (state_q == ST_GNT0) && r_ack;
  assign m0_err_o = (state_q == ST_GNT0) && (r_err || dec_err_q || to_err_q);
  assign m0_rty_o = (state_q == ST_GNT0) && r_rty;
  assign m1_dat_o = (state_q == ST_GNT1) ? r_dat : '0;
  assign m1_ack_o = (state_q == ST_GNT1) && r_ack;
  assign m1_err_o = (state_q == ST_GNT1) && (r_err || dec_err_q || to_err_q);
  assign m1_rty_o = (state_q == ST_GNT1) && r_rty;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed-plus-random bench for wishbone_arbiter; expectations come from an
// address-window / round-robin model. Honours WB_ARB_TIMEOUT_EN like the DUT.
module tb_wishbone_arbiter;
  import wishbone_arbiter_pkg::*;

  localparam int unsigned TO_TB = 8;

  logic clk = 1'b0;
  logic rst_i;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic [31:0] s0_dat_i, s1_dat_i, s2_dat_i;
  logic s0_ack_i, s0_err_i, s0_rty_i, s1_ack_i, s1_err_i, s1_rty_i;
  logic s2_ack_i, s2_err_i, s2_rty_i;
  arb_state_t dbg_state_o;

  int checks   = 0;
  int failures = 0;
  int rr_m     = 1;   // model: index of last granted master

  always #5 clk = ~clk;

  wishbone_arbiter #(.TIMEOUT_CYCLES(TO_TB)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s0_dat_i(s0_dat_i), .s0_ack_i(s0_ack_i), .s0_err_i(s0_err_i), .s0_rty_i(s0_rty_i),
    .s1_dat_i(s1_dat_i), .s1_ack_i(s1_ack_i), .s1_err_i(s1_err_i), .s1_rty_i(s1_rty_i),
    .s2_dat_i(s2_dat_i), .s2_ack_i(s2_ack_i), .s2_err_i(s2_err_i), .s2_rty_i(s2_rty_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model ----------------
  function automatic longint unsigned base_of(input int k);
    case (k)
      0:       return 64'h1000_0000;
      1:       return 64'h2000_0000;
      default: return 64'h3000_0000;
    endcase
  endfunction

  function automatic longint unsigned size_of(input int k);
    case (k)
      0:       return 64'h20_0000;
      1:       return 64'h4000;
      default: return 64'h100;
    endcase
  endfunction

  function automatic int exp_slave(input logic [31:0] a);
    longint unsigned av;
    av = {32'd0, a};
    for (int k = 0; k < 3; k++)
      if (av >= base_of(k) && av < base_of(k) + size_of(k)) return k;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int s);
    return (s >= 0) ? (32'd1 << s) : 32'd0;
  endfunction

  function automatic logic [31:0] rand_addr(input int k);
    longint unsigned off;
    off = 64'($urandom_range(0, 32'(size_of(k) / 4) - 1)) * 4;
    return 32'(base_of(k) + off);
  endfunction

  // ---------------- driver / observer helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic slave_set(input int k, input logic ack, input logic err, input logic rty,
                           input logic [31:0] dat);
    case (k)
      0: begin s0_ack_i = ack; s0_err_i = err; s0_rty_i = rty; s0_dat_i = dat; end
      1: begin s1_ack_i = ack; s1_err_i = err; s1_rty_i = rty; s1_dat_i = dat; end
      default: begin s2_ack_i = ack; s2_err_i = err; s2_rty_i = rty; s2_dat_i = dat; end
    endcase
  endtask

  task automatic slave_clear();
    for (int k = 0; k < 3; k++) slave_set(k, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  function automatic logic get_ack(input int m); return (m == 0) ? m0_ack_o : m1_ack_o; endfunction
  function automatic logic get_err(input int m); return (m == 0) ? m0_err_o : m1_err_o; endfunction
  function automatic logic get_rty(input int m); return (m == 0) ? m0_rty_o : m1_rty_o; endfunction
  function automatic logic [31:0] get_dat(input int m); return (m == 0) ? m0_dat_o : m1_dat_o; endfunction

  function automatic arb_state_t gnt_of(input int m);
    return (m == 0) ? ST_GNT0 : ST_GNT1;
  endfunction

  // One lone-master access from an idle bus; kind: 0 ack, 1 err, 2 rty, 3 ack+err.
  task automatic xfer(input int m, input logic [31:0] adr, input logic we, input int waits,
                      input logic [31:0] rdat, input int kind);
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          s;
    wdat = $urandom;
    sel  = 4'($urandom_range(1, 15));
    s    = exp_slave(adr);
    drive_m(m, 1'b1, 1'b1, we, adr, wdat, sel);
    step();
    rr_m = m;
    check("grant", dbg_state_o, gnt_of(m));
    check("s_cyc", s_cyc_o, onehot(s));
    check("s_stb", s_stb_o, onehot(s));
    check("s_adr", s_adr_o, adr);
    check("s_we", s_we_o, we);
    check("s_dat", s_dat_o, wdat);
    check("s_sel", s_sel_o, sel);
    if (s >= 0) begin
      for (int w = 0; w < waits; w++) begin
        check("wait_ack", get_ack(m), 1'b0);
        check("wait_err", get_err(m), 1'b0);
        step();
      end
      slave_set(s, kind == 0 || kind == 3, kind == 1 || kind == 3, kind == 2, rdat);
      #1;
      check("m_ack", get_ack(m), kind == 0 || kind == 3);
      check("m_err", get_err(m), kind == 1 || kind == 3);
      check("m_rty", get_rty(m), kind == 2);
      check("m_dat", get_dat(m), rdat);
      check("other_ack", get_ack(1 - m), 1'b0);
      check("other_dat", get_dat(1 - m), 32'd0);
      step();
      drive_m(m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      slave_clear();
    end else begin
      check("miss_err_early", get_err(m), 1'b0);
      step();
      check("miss_err", get_err(m), 1'b1);
      check("miss_ack", get_ack(m), 1'b0);
      step();
      check("miss_err_gap", get_err(m), 1'b0);
      drive_m(m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end
    step();
    check("back_idle", dbg_state_o, ST_IDLE);
  endtask

  // Both masters request in the same idle cycle; model picks the winner.
  task automatic both();
    logic [31:0] a [2];
    logic [31:0] d;
    int          w, l;
    a[0] = rand_addr($urandom_range(0, 2));
    a[1] = rand_addr($urandom_range(0, 2));
    drive_m(0, 1'b1, 1'b1, 1'b0, a[0], 32'd0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, a[1], 32'd0, 4'hF);
    step();
    w = (rr_m == 1) ? 0 : 1;
    l = 1 - w;
    rr_m = w;
    check("both_grant", dbg_state_o, gnt_of(w));
    check("both_stb", s_stb_o, onehot(exp_slave(a[w])));
    d = $urandom;
    slave_set(exp_slave(a[w]), 1'b1, 1'b0, 1'b0, d);
    #1;
    check("win_ack", get_ack(w), 1'b1);
    check("win_dat", get_dat(w), d);
    check("lose_ack", get_ack(l), 1'b0);
    check("lose_dat", get_dat(l), 32'd0);
    step();
    drive_m(w, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    slave_clear();
    step();
    check("both_idle", dbg_state_o, ST_IDLE);
    check("idle_lose_ack", get_ack(l), 1'b0);
    step();
    rr_m = l;
    check("lose_grant", dbg_state_o, gnt_of(l));
    check("lose_stb", s_stb_o, onehot(exp_slave(a[l])));
    d = $urandom;
    slave_set(exp_slave(a[l]), 1'b1, 1'b0, 1'b0, d);
    #1;
    check("lose_ack_late", get_ack(l), 1'b1);
    check("lose_dat_late", get_dat(l), d);
    step();
    drive_m(l, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    slave_clear();
    step();
    check("both_idle2", dbg_state_o, ST_IDLE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] bnd [8];
    logic [31:0] a;
    int          cnt, err_at, m, cat;

    // ---- clock/reset ----
    rst_i = 1'b1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    slave_clear();
    repeat (3) step();
    check("rst_state", dbg_state_o, ST_IDLE);
    check("rst_s_cyc", s_cyc_o, 3'b000);
    check("rst_s_stb", s_stb_o, 3'b000);
    check("rst_s_adr", s_adr_o, 32'd0);
    check("rst_m0_err", m0_err_o, 1'b0);
    check("rst_m1_ack", m1_ack_o, 1'b0);
    rst_i = 1'b0;
    rr_m  = 1;
    step();

    // ---- simultaneous requests after reset: m0 first, then alternating ----
    repeat (3) both();

    // ---- directed read: memory acks on second grant cycle ----
    xfer(0, 32'h2000_0010, 1'b0, 1, 32'hDEAD_BEEF, 0);
    // ---- unmapped read ----
    xfer(0, 32'h4000_0000, 1'b0, 0, 32'd0, 0);

    // ---- window boundaries ----
    bnd = '{32'h2000_3FFC, 32'h2000_4000, 32'h101F_FFFC, 32'h1020_0000,
            32'h0FFF_FFFC, 32'h3000_00FC, 32'h3000_0100, 32'hFFFF_FFFC};
    foreach (bnd[i]) xfer(i % 2, bnd[i], 1'($urandom_range(0, 1)), 0, $urandom, 0);

    // ---- random single-master traffic ----
    repeat (24) begin
      m   = $urandom_range(0, 1);
      cat = $urandom_range(0, 4);
      a   = (cat < 3) ? rand_addr(cat) : (32'h4000_0000 + ($urandom & 32'h0FFF_FFFC));
      xfer(m, a, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom, $urandom_range(0, 3));
    end

    // ---- m1 blocked while m0 holds flash ----
    drive_m(0, 1'b1, 1'b1, 1'b0, rand_addr(0), 32'd0, 4'hF);
    step();
    rr_m = 0;
    check("lock_grant", dbg_state_o, ST_GNT0);
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    slave_set(2, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check("lock_state", dbg_state_o, ST_GNT0);
      check("lock_stb", s_stb_o, 3'b001);
      check("lock_m1_ack", m1_ack_o, 1'b0);
      check("lock_m1_dat", m1_dat_o, 32'd0);
    end
    slave_set(0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    #1;
    check("lock_m0_ack", m0_ack_o, 1'b1);
    check("lock_m1_ack2", m1_ack_o, 1'b0);
    step();
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    slave_clear();
    step();
    check("lock_idle", dbg_state_o, ST_IDLE);
    check("lock_idle_ack", m1_ack_o, 1'b0);
    step();
    rr_m = 1;
    check("lock_m1_grant", dbg_state_o, ST_GNT1);
    check("lock_m1_stb", s_stb_o, 3'b100);
    check("lock_m1_we", s_we_o, 1'b1);
    check("lock_m1_sdat", s_dat_o, 32'h1234_5678);
    slave_set(2, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    check("lock_m1_ack3", m1_ack_o, 1'b1);
    step();
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    slave_clear();
    step();

    // ---- reset in the middle of a memory cycle ----
    drive_m(0, 1'b1, 1'b1, 1'b0, rand_addr(1), 32'd0, 4'hF);
    step();
    check("rst_mid_grant", dbg_state_o, ST_GNT0);
    slave_set(1, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
    rst_i = 1'b1;
    step();
    rr_m = 1;
    check("rst_mid_cyc", s_cyc_o, 3'b000);
    check("rst_mid_stb", s_stb_o, 3'b000);
    check("rst_mid_state", dbg_state_o, ST_IDLE);
    check("rst_mid_ack", m0_ack_o, 1'b0);
    check("rst_mid_dat", m0_dat_o, 32'd0);
    rst_i = 1'b0;
    slave_clear();
    drive_m(1, 1'b1, 1'b1, 1'b0, rand_addr(2), 32'd0, 4'hF);
    step();
    rr_m = 0;
    check("rst_mid_regrant", dbg_state_o, ST_GNT0);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) step();

    // ---- silent control slave ----
    drive_m(0, 1'b1, 1'b1, 1'b0, rand_addr(2), 32'd0, 4'hF);
    step();
    cnt    = 0;
    err_at = 0;
    for (int i = 0; i < 3 * int'(TO_TB) + 4; i++) begin
      if (s_stb_o[2]) cnt++;
      if (m0_err_o && err_at == 0) err_at = cnt;
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("timeout_cycle", 32'(err_at), TO_TB);
`else
    check("no_timeout", 32'(err_at), 32'd0);
`endif
    check("silent_stb_held", 32'(cnt), 32'(3 * TO_TB + 4));
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) step();
    check("final_idle", dbg_state_o, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
